uart_cfg: RTL and testbench
===========================

Name: uart_cfg

Overview:
Parametrised, runtime-configurable UART with buffered RX and TX paths. It adds per-word parity, configurable stop length and glitch-rejecting start detection, and reports per-word errors plus a sticky RX overrun flag. It reuses the codebase's baud_rate_generator (16x oversampling tick) and fifo, and contains new RX and TX serial engines. It sits between the host register interface and the serial pins.

Parameters:
DBITS, 8, data bits per frame (5..9)
SB_TICK, 16, stop-length in oversample ticks (16 = 1 stop, 24 = 1.5 stop, 32 = 2 stop)
FIFO_AW, 4, FIFO address bits; depth = 2**FIFO_AW per direction
DVSR_W, 11, width of the baud divisor

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
final_value  in  DVSR_W  baud divisor; tick every final_value+1 clk cycles
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
rd  in  1  pop RX FIFO head
wr  in  1  push w_data into TX FIFO
w_data  in  DBITS  TX word
rx  in  1  serial input (idle high, pre-synchronised)
clr_err  in  1  clear sticky rx_overrun
tx  out  1  serial output
r_data  out  DBITS  RX FIFO head data
rx_parity_err  out  1  parity error flag of the head word
rx_frame_err  out  1  framing error flag of the head word
rx_overrun  out  1  sticky: a received word was dropped because RX FIFO was full
rx_empty  out  1  RX FIFO empty
tx_full  out  1  TX FIFO full

Behaviour:
- Reset (sync, rst=1 at clk edge): tx=1; both FIFOs empty (rx_empty=1, tx_full=0); rx_overrun=0; both FSMs go to IDLE; tick counters cleared. Reset mid-frame abandons the frame with no FIFO push or pop.
- All timing below is in baud ticks (16 per bit). parity_mode is latched at frame start and held for the whole frame.
- RX FSM, states IDLE -> START -> DATA -> PARITY -> STOP -> IDLE:
  - IDLE: on rx=0, enter START with tick count 0.
  - START: at tick 7 (mid-bit), re-sample rx. If rx=1, return to IDLE (glitch reject, nothing pushed). If rx=0, enter DATA.
  - DATA: sample every 16 ticks, LSB first, DBITS samples.
  - PARITY: entered only if parity is enabled; one bit, sampled after 16 ticks. Error when the XOR of data and parity bit is 1 (even) or 0 (odd).
  - STOP: wait SB_TICK ticks and sample rx at the last tick; rx=0 means frame error.
  - On STOP exit, push {frame_err, parity_err, data} (DBITS+2 wide) into the RX FIFO in a single cycle.
  - If the RX FIFO is full at push: drop the word and set rx_overrun=1.
  - rx_overrun stays set until clr_err=1. If clr_err and a new overrun occur in the same cycle, the set wins.
- TX FSM, states IDLE -> START -> DATA -> PARITY -> STOP -> IDLE:
  - IDLE: tx=1. When the TX FIFO is non-empty, latch the head word and parity_mode, then enter START.
  - START: drive 0 for 16 ticks.
  - DATA: drive DBITS bits, LSB first, 16 ticks each.
  - PARITY: if enabled, drive the parity bit for 16 ticks.
  - STOP: drive 1 for SB_TICK ticks.
  - Pop the TX FIFO for exactly one cycle at STOP exit. The next frame may start on the following tick with no added idle bit.
- FIFO interface:
  - First-word-fall-through: r_data and the error flags always show the head entry.
  - rd while rx_empty=1 is ignored; wr while tx_full=1 is ignored (word lost, no flag).
  - A simultaneous push and pop on the same FIFO is legal and leaves the count unchanged.
  - rd pops head data and head flags together.
- Latency:
  - RX: a word is visible on r_data one clk after STOP completes.
  - TX: frame start occurs on the first tick at or after the cycle following the wr into an empty FIFO.
- final_value changes take effect at the next baud generator wrap. A change mid-frame is not protected.

Decomposition:
- Shared package uart_pkg:
  - parity_mode encodings (PAR_NONE, PAR_EVEN, PAR_ODD)
  - FSM state enum: IDLE, START, DATA, PARITY, STOP (shared by RX and TX)
  - OVERSAMPLE = 16 constant
- Sub-modules:
  - Reused: baud_rate_generator; fifo, instantiated twice (RX width DBITS+2, TX width DBITS).
  - New, natural split: uart_rx_par (RX engine with parity, framing and glitch reject).
  - The TX engine stays inline in uart_cfg.

Test Plan:
- Setup for all scenarios: final_value=3 (tick every 4 clk), DBITS=8, loopback tx->rx.
- No parity: write 0xA5 -> tx shows 0, 1,0,1,0,0,1,0,1, 1 at 16 ticks/bit; r_data=0xA5 with both error flags 0.
- Even parity, 0x07 -> parity bit 1 on tx; odd parity -> parity bit 0; both read back with rx_parity_err=0. Inject a flipped parity bit on rx -> rx_parity_err=1 with r_data=0x07.
- Drive rx stop bit low for 0x3C -> rx_frame_err=1, r_data=0x3C. A 4-tick low pulse on idle rx -> nothing pushed, rx_empty stays 1.
- Send 17 frames with FIFO_AW=4 and no reads -> 16 stored, rx_overrun=1. Read all 16 in order. clr_err -> rx_overrun=0.
- Write 16 words back-to-back -> tx_full=1, and a 17th wr is ignored. Back-to-back frames have no idle gap. Assert rst mid-DATA -> tx=1 next clk and both FIFOs empty.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parity encodings, FSM states and oversample constant for uart_cfg
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // 2'b11 is a reserved code and behaves like PAR_NONE
    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_cfg_if.sv
// rtl/uart_cfg_if.sv - host-side configuration, FIFO access and status bundle of uart_cfg
interface uart_cfg_if #(
    parameter int DBITS  = 8,
    parameter int DVSR_W = 11
);
    logic [DVSR_W-1:0] final_value;
    logic [1:0]        parity_mode;
    logic              rd;
    logic              wr;
    logic [DBITS-1:0]  w_data;
    logic              clr_err;
    logic [DBITS-1:0]  r_data;
    logic              rx_parity_err;
    logic              rx_frame_err;
    logic              rx_overrun;
    logic              rx_empty;
    logic              tx_full;

    modport master (
        output final_value, parity_mode, rd, wr, w_data, clr_err,
        input  r_data, rx_parity_err, rx_frame_err, rx_overrun, rx_empty, tx_full
    );

    modport slave (
        input  final_value, parity_mode, rd, wr, w_data, clr_err,
        output r_data, rx_parity_err, rx_frame_err, rx_overrun, rx_empty, tx_full
    );
endinterface

// File: rtl/baud_rate_generator.sv
// rtl/baud_rate_generator.sv - oversample tick every final_value+1 clocks
module baud_rate_generator #(
    parameter int DVSR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DVSR_W-1:0] final_value,
    output logic              tick
);
    logic [DVSR_W-1:0] cnt;
    logic [DVSR_W-1:0] limit;

    // divisor is reloaded only at wrap so a change never truncates a period
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            limit <= final_value;
        end else if (cnt == limit) begin
            cnt   <= '0;
            limit <= final_value;
        end else begin
            cnt   <= cnt + DVSR_W'(1);
        end
    end

    assign tick = (cnt == limit);
endmodule

// File: rtl/fifo.sv
// rtl/fifo.sv - first-word-fall-through synchronous FIFO, depth 2**AW
module fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rd,
    input  logic         wr,
    input  logic [W-1:0] w_data,
    output logic [W-1:0] r_data,
    output logic         empty,
    output logic         full
);
    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         wr_en;
    logic         rd_en;

    assign wr_en = wr && !full;
    assign rd_en = rd && !empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[AW-1:0]] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + (AW+1)'(1);
            if (rd_en) rptr <= rptr + (AW+1)'(1);
        end
    end

    assign r_data = mem[rptr[AW-1:0]];
    assign empty  = (wptr == rptr);
    assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
endmodule

// File: rtl/uart_rx_par.sv
// rtl/uart_rx_par.sv - oversampled RX engine with parity check, framing check and start glitch reject
module uart_rx_par
    import uart_pkg::*;
#(
    parameter int DBITS   = 8,
    parameter int SB_TICK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic             s_tick,
    input  logic [1:0]       parity_mode,
    output logic             rx_done,
    output logic [DBITS+1:0] rx_word
);
    uart_state_t      state, state_n;
    logic [5:0]       s, s_n;
    logic [3:0]       n, n_n;
    logic [DBITS-1:0] b, b_n;
    logic             par_on, par_on_n;
    logic             odd, odd_n;
    logic             perr, perr_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            s      <= '0;
            n      <= '0;
            b      <= '0;
            par_on <= 1'b0;
            odd    <= 1'b0;
            perr   <= 1'b0;
        end else begin
            state  <= state_n;
            s      <= s_n;
            n      <= n_n;
            b      <= b_n;
            par_on <= par_on_n;
            odd    <= odd_n;
            perr   <= perr_n;
        end
    end

    always_comb begin
        state_n  = state;
        s_n      = s;
        n_n      = n;
        b_n      = b;
        par_on_n = par_on;
        odd_n    = odd;
        perr_n   = perr;
        rx_done  = 1'b0;
        // frame error bit is the live stop sample, valid in the rx_done cycle
        rx_word  = {~rx, perr, b};
        case (state)
            IDLE: begin
                if (!rx) begin
                    state_n  = START;
                    s_n      = '0;
                    par_on_n = par_enabled(parity_mode);
                    odd_n    = (parity_mode == PAR_ODD);
                    perr_n   = 1'b0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == 6'(OVERSAMPLE/2 - 1)) begin
                        if (rx) begin
                            state_n = IDLE;
                        end else begin
                            state_n = DATA;
                            s_n     = '0;
                            n_n     = '0;
                        end
                    end else begin
                        s_n = s + 6'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == 6'(OVERSAMPLE - 1)) begin
                        s_n = '0;
                        b_n = {rx, b[DBITS-1:1]};
                        if (n == 4'(DBITS - 1)) begin
                            state_n = par_on ? PARITY : STOP;
                        end else begin
                            n_n = n + 4'd1;
                        end
                    end else begin
                        s_n = s + 6'd1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s == 6'(OVERSAMPLE - 1)) begin
                        s_n     = '0;
                        perr_n  = (^b) ^ rx ^ odd;
                        state_n = STOP;
                    end else begin
                        s_n = s + 6'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == 6'(SB_TICK - 1)) begin
                        rx_done = 1'b1;
                        state_n = IDLE;
                    end else begin
                        s_n = s + 6'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: rtl/uart_cfg.sv
// rtl/uart_cfg.sv - configurable UART top: baud generator, RX/TX FIFOs, RX engine and inline TX engine
module uart_cfg
    import uart_pkg::*;
#(
    parameter int DBITS   = 8,
    parameter int SB_TICK = 16,
    parameter int FIFO_AW = 4,
    parameter int DVSR_W  = 11
) (
    input  logic       clk,
    input  logic       rst,
    uart_cfg_if.slave  host,
    input  logic       rx,
    output logic       tx
);
    logic             tick;
    logic             rx_done;
    logic [DBITS+1:0] rx_word;
    logic [DBITS+1:0] rx_head;
    logic             rx_full;
    logic             rx_empty;
    logic             overrun;
    logic [DBITS-1:0] tx_head;
    logic             tx_empty;
    logic             tx_full;
    logic             tx_pop;

    baud_rate_generator #(.DVSR_W(DVSR_W)) u_baud (
        .clk         (clk),
        .rst         (rst),
        .final_value (host.final_value),
        .tick        (tick)
    );

    uart_rx_par #(.DBITS(DBITS), .SB_TICK(SB_TICK)) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .s_tick      (tick),
        .parity_mode (host.parity_mode),
        .rx_done     (rx_done),
        .rx_word     (rx_word)
    );

    fifo #(.W(DBITS+2), .AW(FIFO_AW)) u_rx_fifo (
        .clk    (clk),
        .rst    (rst),
        .rd     (host.rd),
        .wr     (rx_done),
        .w_data (rx_word),
        .r_data (rx_head),
        .empty  (rx_empty),
        .full   (rx_full)
    );

    fifo #(.W(DBITS), .AW(FIFO_AW)) u_tx_fifo (
        .clk    (clk),
        .rst    (rst),
        .rd     (tx_pop),
        .wr     (host.wr),
        .w_data (host.w_data),
        .r_data (tx_head),
        .empty  (tx_empty),
        .full   (tx_full)
    );

    // a new overrun outranks a clear in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (rx_done && rx_full) begin
            overrun <= 1'b1;
        end else if (host.clr_err) begin
            overrun <= 1'b0;
        end
    end

    assign host.r_data        = rx_head[DBITS-1:0];
    assign host.rx_parity_err = rx_head[DBITS];
    assign host.rx_frame_err  = rx_head[DBITS+1];
    assign host.rx_overrun    = overrun;
    assign host.rx_empty      = rx_empty;
    assign host.tx_full       = tx_full;

    uart_state_t      tx_state, tx_state_n;
    logic [5:0]       tx_s, tx_s_n;
    logic [3:0]       tx_n, tx_n_n;
    logic [DBITS-1:0] tx_b, tx_b_n;
    logic             tx_par_on, tx_par_on_n;
    logic             tx_par_bit, tx_par_bit_n;
    logic             tx_q, tx_q_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state   <= IDLE;
            tx_s       <= '0;
            tx_n       <= '0;
            tx_b       <= '0;
            tx_par_on  <= 1'b0;
            tx_par_bit <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state   <= tx_state_n;
            tx_s       <= tx_s_n;
            tx_n       <= tx_n_n;
            tx_b       <= tx_b_n;
            tx_par_on  <= tx_par_on_n;
            tx_par_bit <= tx_par_bit_n;
            tx_q       <= tx_q_n;
        end
    end

    always_comb begin
        tx_state_n   = tx_state;
        tx_s_n       = tx_s;
        tx_n_n       = tx_n;
        tx_b_n       = tx_b;
        tx_par_on_n  = tx_par_on;
        tx_par_bit_n = tx_par_bit;
        tx_q_n       = tx_q;
        tx_pop       = 1'b0;
        case (tx_state)
            IDLE: begin
                tx_q_n = 1'b1;
                if (tick && !tx_empty) begin
                    tx_state_n   = START;
                    tx_s_n       = '0;
                    tx_b_n       = tx_head;
                    tx_par_on_n  = par_enabled(host.parity_mode);
                    tx_par_bit_n = (^tx_head) ^ (host.parity_mode == PAR_ODD);
                    tx_q_n       = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    if (tx_s == 6'(OVERSAMPLE - 1)) begin
                        tx_state_n = DATA;
                        tx_s_n     = '0;
                        tx_n_n     = '0;
                        tx_q_n     = tx_b[0];
                    end else begin
                        tx_s_n = tx_s + 6'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tx_s == 6'(OVERSAMPLE - 1)) begin
                        tx_s_n = '0;
                        tx_b_n = {1'b0, tx_b[DBITS-1:1]};
                        if (tx_n == 4'(DBITS - 1)) begin
                            tx_state_n = tx_par_on ? PARITY : STOP;
                            tx_q_n     = tx_par_on ? tx_par_bit : 1'b1;
                        end else begin
                            tx_n_n = tx_n + 4'd1;
                            tx_q_n = tx_b[1];
                        end
                    end else begin
                        tx_s_n = tx_s + 6'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (tx_s == 6'(OVERSAMPLE - 1)) begin
                        tx_state_n = STOP;
                        tx_s_n     = '0;
                        tx_q_n     = 1'b1;
                    end else begin
                        tx_s_n = tx_s + 6'd1;
                    end
                end
            end
            STOP: begin
                // the IDLE tick that launches the next word supplies the last stop tick
                if (tick) begin
                    if (tx_s == 6'(SB_TICK - 2)) begin
                        tx_state_n = IDLE;
                        tx_pop     = 1'b1;
                    end else begin
                        tx_s_n = tx_s + 6'd1;
                    end
                end
            end
            default: tx_state_n = IDLE;
        endcase
    end

    assign tx = tx_q;
endmodule

// File: tb/tb_uart_cfg.sv
// tb/tb_uart_cfg.sv - directed self-checking bench for uart_cfg
module tb_uart_cfg;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rx_drv;
    logic loop_en;
    logic tx;
    logic rx;
    int   total = 0;
    int   bad   = 0;

    uart_cfg_if #(.DBITS(8), .DVSR_W(11)) bus ();

    assign rx = loop_en ? tx : rx_drv;

    uart_cfg #(.DBITS(8), .SB_TICK(16), .FIFO_AW(4), .DVSR_W(11)) dut (
        .clk  (clk),
        .rst  (rst),
        .host (bus),
        .rx   (rx),
        .tx   (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        bus.clr_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] d);
        @(negedge clk);
        bus.w_data = d;
        bus.wr = 1'b1;
        @(negedge clk);
        bus.wr = 1'b0;
    endtask

    task automatic pop_rx();
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_rx(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!bus.rx_empty) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_tx_fall(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (tx == 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // one bit = 16 ticks * 4 clk = 64 clk; sample each bit at its centre
    task automatic capture_frame(input int nbits, output logic [15:0] bits, output bit ok);
        bits = '0;
        wait_tx_fall(200, ok);
        if (ok) begin
            repeat (32) @(negedge clk);
            bits[0] = tx;
            for (int k = 1; k < nbits; k++) begin
                repeat (64) @(negedge clk);
                bits[k] = tx;
            end
        end
    endtask

    task automatic drive_frame(input logic [7:0] d, input bit par_on, input logic par, input bit stop_low);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (64) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_drv = d[k];
            repeat (64) @(negedge clk);
        end
        if (par_on) begin
            rx_drv = par;
            repeat (64) @(negedge clk);
        end
        if (stop_low) begin
            rx_drv = 1'b0;
            repeat (40) @(negedge clk);
            rx_drv = 1'b1;
            repeat (24) @(negedge clk);
        end else begin
            rx_drv = 1'b1;
            repeat (64) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
        total++; if (bus.rx_empty !== 1'b1) begin bad++; $display("FAIL reset_rx_empty got=%b want=1", bus.rx_empty); end
        total++; if (bus.tx_full !== 1'b0) begin bad++; $display("FAIL reset_tx_full got=%b want=0", bus.tx_full); end
        total++; if (bus.rx_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", bus.rx_overrun); end
    endtask

    task automatic test_no_parity();
        logic [15:0] bits;
        bit ok;
        loop_en = 1'b1;
        bus.parity_mode = PAR_NONE;
        push_tx(8'hA5);
        capture_frame(10, bits, ok);
        total++; if (!ok || bits[9:0] !== 10'b1_1010_0101_0) begin
            bad++; $display("FAIL np_tx_bits got=%b want=%b seen=%0d", bits[9:0], 10'b1_1010_0101_0, ok);
        end
        wait_rx(300, ok);
        total++; if (!ok || bus.r_data !== 8'hA5 || bus.rx_parity_err !== 1'b0 || bus.rx_frame_err !== 1'b0) begin
            bad++; $display("FAIL np_rx got=%h pe=%b fe=%b want=a5 pe=0 fe=0", bus.r_data, bus.rx_parity_err, bus.rx_frame_err);
        end
        pop_rx();
        total++; if (bus.rx_empty !== 1'b1) begin bad++; $display("FAIL np_empty_after_rd got=%b want=1", bus.rx_empty); end
        repeat (100) @(negedge clk);
    endtask

    task automatic test_parity(input logic [1:0] mode, input logic exp_par, input string name);
        logic [15:0] bits;
        logic [10:0] exp;
        bit ok;
        loop_en = 1'b1;
        bus.parity_mode = mode;
        exp = {1'b1, exp_par, 8'h07, 1'b0};
        push_tx(8'h07);
        capture_frame(11, bits, ok);
        total++; if (!ok || bits[10:0] !== exp) begin
            bad++; $display("FAIL %s_tx_bits got=%b want=%b", name, bits[10:0], exp);
        end
        wait_rx(300, ok);
        total++; if (!ok || bus.r_data !== 8'h07 || bus.rx_parity_err !== 1'b0 || bus.rx_frame_err !== 1'b0) begin
            bad++; $display("FAIL %s_rx got=%h pe=%b fe=%b want=07 pe=0 fe=0", name, bus.r_data, bus.rx_parity_err, bus.rx_frame_err);
        end
        pop_rx();
        repeat (100) @(negedge clk);
    endtask

    task automatic test_rx_errors();
        bit ok;
        loop_en = 1'b0;
        rx_drv = 1'b1;
        bus.parity_mode = PAR_EVEN;
        drive_frame(8'h07, 1'b1, 1'b0, 1'b0);
        wait_rx(300, ok);
        total++; if (!ok || bus.r_data !== 8'h07 || bus.rx_parity_err !== 1'b1 || bus.rx_frame_err !== 1'b0) begin
            bad++; $display("FAIL par_inject got=%h pe=%b fe=%b want=07 pe=1 fe=0", bus.r_data, bus.rx_parity_err, bus.rx_frame_err);
        end
        pop_rx();
        bus.parity_mode = PAR_NONE;
        drive_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        wait_rx(300, ok);
        total++; if (!ok || bus.r_data !== 8'h3C || bus.rx_frame_err !== 1'b1 || bus.rx_parity_err !== 1'b0) begin
            bad++; $display("FAIL frame_err got=%h pe=%b fe=%b want=3c pe=0 fe=1", bus.r_data, bus.rx_parity_err, bus.rx_frame_err);
        end
        pop_rx();
        repeat (300) @(negedge clk);
        total++; if (bus.rx_empty !== 1'b1) begin bad++; $display("FAIL frame_err_tail got_empty=%b want=1", bus.rx_empty); end
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        rx_drv = 1'b1;
        repeat (800) @(negedge clk);
        total++; if (bus.rx_empty !== 1'b1) begin bad++; $display("FAIL glitch_reject got_empty=%b want=1", bus.rx_empty); end
    endtask

    task automatic test_overrun();
        bit ok;
        do_reset();
        loop_en = 1'b1;
        bus.parity_mode = PAR_NONE;
        for (int i = 0; i < 17; i++) begin
            ok = 1'b0;
            for (int c = 0; c < 1500; c++) begin
                if (!bus.tx_full) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            total++; if (!ok) begin bad++; $display("FAIL ovr_tx_full_stuck word=%0d got_full=1 want=0", i); end
            push_tx(8'h40 + i[7:0]);
        end
        ok = 1'b0;
        for (int c = 0; c < 14000; c++) begin
            if (bus.rx_overrun) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        total++; if (!ok) begin bad++; $display("FAIL ovr_set got=%b want=1", bus.rx_overrun); end
        repeat (200) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            total++; if (bus.rx_empty !== 1'b0 || bus.r_data !== (8'h40 + i[7:0])) begin
                bad++; $display("FAIL ovr_read idx=%0d got=%h empty=%b want=%h", i, bus.r_data, bus.rx_empty, 8'h40 + i[7:0]);
            end
            pop_rx();
        end
        total++; if (bus.rx_empty !== 1'b1) begin bad++; $display("FAIL ovr_drained got_empty=%b want=1", bus.rx_empty); end
        total++; if (bus.rx_overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", bus.rx_overrun); end
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        @(negedge clk);
        total++; if (bus.rx_overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", bus.rx_overrun); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int el;
        do_reset();
        loop_en = 1'b1;
        bus.parity_mode = PAR_NONE;
        push_tx(8'h80);
        wait_tx_fall(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_first_start got_tx=%b want=0", tx); end
        el = 0;
        for (int i = 1; i < 17; i++) begin
            bus.w_data = 8'h80 + i[7:0];
            bus.wr = 1'b1;
            @(negedge clk);
            el++;
        end
        bus.wr = 1'b0;
        total++; if (bus.tx_full !== 1'b1) begin bad++; $display("FAIL b2b_tx_full got=%b want=1", bus.tx_full); end
        repeat (639 - el) @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL b2b_stop_end got=%b want=1", tx); end
        @(negedge clk);
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL b2b_no_gap got=%b want=0", tx); end
        repeat (10000) @(negedge clk);
        total++; if (bus.rx_overrun !== 1'b0 || tx !== 1'b1) begin
            bad++; $display("FAIL b2b_17th_ignored overrun=%b tx=%b want overrun=0 tx=1", bus.rx_overrun, tx);
        end
        for (int i = 0; i < 16; i++) begin
            total++; if (bus.rx_empty !== 1'b0 || bus.r_data !== (8'h80 + i[7:0])) begin
                bad++; $display("FAIL b2b_read idx=%0d got=%h empty=%b want=%h", i, bus.r_data, bus.rx_empty, 8'h80 + i[7:0]);
            end
            pop_rx();
        end
        total++; if (bus.rx_empty !== 1'b1) begin bad++; $display("FAIL b2b_drained got_empty=%b want=1", bus.rx_empty); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int lows;
        do_reset();
        loop_en = 1'b1;
        bus.parity_mode = PAR_NONE;
        push_tx(8'h55);
        push_tx(8'h66);
        wait_tx_fall(200, ok);
        repeat (64 * 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (!ok || tx !== 1'b1) begin bad++; $display("FAIL rst_mid_tx got=%b want=1", tx); end
        total++; if (bus.rx_empty !== 1'b1 || bus.tx_full !== 1'b0) begin
            bad++; $display("FAIL rst_mid_fifos empty=%b full=%b want empty=1 full=0", bus.rx_empty, bus.tx_full);
        end
        rst = 1'b0;
        lows = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
        total++; if (lows !== 0 || bus.rx_empty !== 1'b1) begin
            bad++; $display("FAIL rst_mid_quiet tx_low_cycles=%0d empty=%b want 0 and 1", lows, bus.rx_empty);
        end
    endtask

    initial begin
        rst = 1'b1;
        loop_en = 1'b1;
        rx_drv = 1'b1;
        bus.final_value = 11'd3;
        bus.parity_mode = PAR_NONE;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        bus.w_data = '0;
        bus.clr_err = 1'b0;
        test_reset();
        test_no_parity();
        test_parity(PAR_EVEN, 1'b1, "even");
        test_parity(PAR_ODD, 1'b0, "odd");
        test_rx_errors();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
